// File: rtl/mem_req_initiator.sv
// mem_req_initiator: takes one load/store/pass-through op from the execute
// stage and runs a req/gnt + rvalid handshake to a data memory.
// It returns the writeback value with a one-cycle result_vld pulse.
// A watchdog aborts any memory wait that runs past TIMEOUT.
//
// Handshake semantics:
//   Execute side: an op is taken on a rising edge only when the block is IDLE
//   and op_valid=1. stall is the back-pressure signal, and it is high while
//   busy or while a load/store is being presented. Inputs seen while busy are
//   ignored.
//   Memory request: mem_req is the valid signal and mem_gnt is the ready signal.
//   The request transfers on a rising edge when both are high. mem_we,
//   mem_addr and mem_wdata are held stable while mem_req=1.
//   Memory response: mem_rvalid is a one-cycle qualifier for mem_rdata. It is
//   used only after the read has been granted, or in the same cycle as the
//   grant. At any other time it is dropped.
module mem_req_initiator #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  input  logic [DW-1:0] alu_in,
  input  logic [DW-1:0] wd,
  input  logic          we,
  input  logic          mr,
  output logic          stall,
  output logic [DW-1:0] result,
  output logic          result_vld,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int TW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            r_mem_req;
  logic            w_mem_req_nxt;
  logic            r_mem_we;
  logic            w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr;
  logic [AW-1:0]   w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   w_mem_wdata_nxt;
  logic [DW-1:0]   r_result;
  logic [DW-1:0]   w_result_nxt;
  logic            r_result_vld;
  logic            w_result_vld_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            w_expired;
  logic            w_mem_op;

  // The watchdog fires on the busy cycle where the timer has reached TIMEOUT.
  assign w_expired = (r_timer == TW'(TIMEOUT));
  assign w_mem_op  = op_valid & (we | mr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next register values.
  // Completions are tested before expiry, so a completion wins a tie.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_result_nxt     = r_result;
    w_result_vld_nxt = 1'b0;
    w_err_nxt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (we | mr) begin
            // A store has priority when both we and mr are set.
            w_mem_addr_nxt  = alu_in[AW-1:0];
            w_mem_wdata_nxt = wd;
            w_mem_we_nxt    = we;
            w_mem_req_nxt   = 1'b1;
            w_timer_nxt     = '0;
            w_state_nxt     = S_REQ;
          end else begin
            w_result_nxt     = alu_in;
            w_result_vld_nxt = 1'b1;
          end
        end
      end
      S_REQ: begin
        w_timer_nxt = r_timer + 1'b1;
        if (mem_gnt && r_mem_we) begin
          w_mem_req_nxt    = 1'b0;
          w_result_nxt     = DW'(r_mem_addr);
          w_result_vld_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (mem_gnt && mem_rvalid) begin
          w_mem_req_nxt    = 1'b0;
          w_result_nxt     = mem_rdata;
          w_result_vld_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (w_expired) begin
          w_mem_req_nxt    = 1'b0;
          w_result_nxt     = {DW{1'b1}};
          w_result_vld_nxt = 1'b1;
          w_err_nxt        = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + 1'b1;
        if (mem_rvalid) begin
          w_result_nxt     = mem_rdata;
          w_result_vld_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (w_expired) begin
          w_result_nxt     = {DW{1'b1}};
          w_result_vld_nxt = 1'b1;
          w_err_nxt        = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_result     <= w_result_nxt;
      r_result_vld <= w_result_vld_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign stall      = (r_state != S_IDLE) | w_mem_op;
  assign result     = r_result;
  assign result_vld = r_result_vld;
  assign err        = r_err;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Testbench for mem_req_initiator.
// It runs directed scenarios first and then a randomized op stream.
// Expected outcomes come from a transaction-level model, which decides from
// the grant and response delays when each op ends and what it returns.
module tb_mem_req_initiator;

  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int TIMEOUT = 4;

  logic          clk;
  logic          rst_n;
  logic          op_valid;
  logic [DW-1:0] alu_in;
  logic [DW-1:0] wd;
  logic          we;
  logic          mr;
  logic          stall;
  logic [DW-1:0] result;
  logic          result_vld;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0]   exp_q[$];     // {err, result} per expected completion
  logic [DW-1:0] last_result;  // last value the result register should hold

  mem_req_initiator #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .alu_in     (alu_in),
    .wd         (wd),
    .we         (we),
    .mr         (mr),
    .stall      (stall),
    .result     (result),
    .result_vld (result_vld),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    op_valid   = 1'b0;
    we         = 1'b0;
    mr         = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Runs one op from a negedge where the DUT is idle.
  // g is the busy-cycle index of the grant, and r is the extra cycles from
  // the grant to rvalid (0 means rvalid arrives with the grant).
  // The task returns positioned at the negedge where result_vld is visible.
  task automatic do_op(input logic we_i, input logic mr_i, input logic [DW-1:0] a,
                       input logic [DW-1:0] d, input int g, input int r,
                       input logic [DW-1:0] rd);
    logic   is_mem;
    logic   is_st;
    int     kend;
    logic [DW:0] exp;
    logic [DW:0] got_exp;
    is_mem = we_i | mr_i;
    is_st  = we_i;
    // Reference model: the outcome follows directly from the delays
    if (!is_mem) begin
      kend = -1; exp = {1'b0, a};
    end else if (g > TIMEOUT) begin
      kend = TIMEOUT; exp = {1'b1, {DW{1'b1}}};
    end else if (is_st) begin
      kend = g; exp = {1'b0, a};
    end else if (g + r <= TIMEOUT) begin
      kend = g + r; exp = {1'b0, rd};
    end else begin
      kend = TIMEOUT; exp = {1'b1, {DW{1'b1}}};
    end
    exp_q.push_back(exp);

    op_valid   = 1'b1;
    we         = we_i;
    mr         = mr_i;
    alu_in     = a;
    wd         = d;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    #1 check_eq("stall_accept", 32'(stall), 32'(is_mem));
    @(negedge clk);
    for (int k = 0; k <= kend; k++) begin
      check_eq("busy_vld", 32'(result_vld), 32'd0);
      check_eq("busy_stall", 32'(stall), 32'd1);
      check_eq("busy_result_hold", 32'(result), 32'(last_result));
      check_eq("mem_req", 32'(mem_req), 32'(k <= g));
      if (k <= g) begin
        check_eq("mem_addr", 32'(mem_addr), 32'(a));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(d));
        check_eq("mem_we", 32'(mem_we), 32'(is_st));
      end
      // Ops offered while busy must be ignored
      op_valid = 1'($urandom_range(0, 1));
      we       = 1'($urandom_range(0, 1));
      mr       = 1'($urandom_range(0, 1));
      alu_in   = DW'($urandom);
      wd       = DW'($urandom);
      // Memory side: real grant/response plus spurious noise
      mem_gnt    = (k == g) || (k > g && $urandom_range(0, 1) == 1);
      mem_rvalid = 1'b0;
      mem_rdata  = DW'($urandom);
      if (k < g && $urandom_range(0, 2) == 0) begin
        mem_rvalid = 1'b1;
      end else if (!is_st && k == g + r) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
      @(negedge clk);
    end
    drive_idle();
    #1;
    got_exp = exp_q.pop_front();
    check_eq("done_vld", 32'(result_vld), 32'd1);
    check_eq("done_result", 32'(result), 32'(got_exp[DW-1:0]));
    check_eq("done_err", 32'(err), 32'(got_exp[DW]));
    check_eq("done_mem_req", 32'(mem_req), 32'd0);
    check_eq("done_stall", 32'(stall), 32'd0);
    last_result = got_exp[DW-1:0];
  endtask

  // A response arriving while idle must be dropped
  task automatic stale_rvalid();
    op_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = DW'($urandom);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("stale_vld", 32'(result_vld), 32'd0);
    check_eq("stale_result", 32'(result), 32'(last_result));
    check_eq("stale_err", 32'(err), 32'd0);
  endtask

  task automatic idle_cycle();
    drive_idle();
    @(negedge clk);
    check_eq("idle_vld", 32'(result_vld), 32'd0);
    check_eq("idle_err", 32'(err), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_result"}, 32'(result), 32'd0);
    check_eq({tag, "_vld"}, 32'(result_vld), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // Starts a load and asserts reset mid-transaction, either while the request
  // is still pending or after it has been granted.
  task automatic reset_mid(input logic after_gnt);
    op_valid = 1'b1; we = 1'b0; mr = 1'b1;
    alu_in = 16'h0F0F; wd = 16'h1111;
    @(negedge clk);
    drive_idle();
    mem_gnt = after_gnt;
    @(negedge clk);
    mem_gnt = 1'b0;
    check_eq("pre_rst_stall", 32'(stall), 32'd1);
    check_eq("pre_rst_req", 32'(mem_req), 32'(!after_gnt));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(after_gnt ? "rst_wait" : "rst_req");
    @(negedge clk);
    check_eq("rst_hold_vld", 32'(result_vld), 32'd0);
    rst_n = 1'b1;
    last_result = '0;
  endtask

  // Stimulus
  initial begin
    int g;
    int r;
    int kind;
    logic we_r;
    logic mr_r;
    rst_n = 1'b0;
    alu_in = '0;
    wd = '0;
    mem_rdata = '0;
    drive_idle();
    last_result = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through
    do_op(1'b0, 1'b0, 16'h1234, 16'h0000, 0, 0, 16'h0000);
    // Store granted on the third request cycle
    do_op(1'b1, 1'b0, 16'h0005, 16'hBEEF, 2, 0, 16'h0000);
    // Zero-latency load
    do_op(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 0, 16'hA5A5);
    // Load with late response landing on the expiry cycle (completion wins)
    do_op(1'b0, 1'b1, 16'h0041, 16'h0000, 1, 3, 16'h5A5A);
    // Timeouts: store never granted, then a load whose data comes too late
    do_op(1'b1, 1'b0, 16'h0077, 16'h1357, 9, 0, 16'h0000);
    stale_rvalid();
    do_op(1'b0, 1'b1, 16'h0078, 16'h0000, 2, 3, 16'hC3C3);
    stale_rvalid();
    do_op(1'b0, 1'b0, 16'h4321, 16'h0000, 0, 0, 16'h0000);
    // Back-to-back: the next op is offered in the result_vld cycle
    do_op(1'b0, 1'b1, 16'h0100, 16'h0000, 0, 1, 16'h9999);
    do_op(1'b1, 1'b0, 16'h0101, 16'h7777, 0, 0, 16'h0000);

    // Reset in REQ and in WAIT; afterwards we=mr=1 must issue a write
    reset_mid(1'b0);
    reset_mid(1'b1);
    do_op(1'b1, 1'b1, 16'h00AA, 16'hCAFE, 1, 0, 16'h0000);

    // Randomized op stream
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      we_r = (kind == 1) || (kind == 3);
      mr_r = (kind == 2) || (kind == 3);
      g    = $urandom_range(0, TIMEOUT + 2);
      r    = $urandom_range(0, 4);
      do_op(we_r, mr_r, DW'($urandom), DW'($urandom), g, r, DW'($urandom));
      case ($urandom_range(0, 3))
        0: stale_rvalid();
        1: idle_cycle();
        default: ;
      endcase
    end

    idle_cycle();
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
